// File: rtl/fpu_op_scheduler.sv
// Single-issue scheduler between an FPU requester and the shared datapath.
// Latches one op, pulses dp_start, waits the opcode latency, holds the response.
module fpu_op_scheduler #(
    parameter int         WIDTH   = 32,
    parameter int         LAT_ADD = 3,
    parameter int         LAT_SUB = 3,
    parameter int         LAT_MUL = 4,
    parameter int         LAT_DIV = 12,
    parameter logic [3:0] OP_EN   = 4'b1111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_opa,
    input  logic [WIDTH-1:0] req_opb,
    output logic             dp_start,
    output logic [1:0]       dp_op,
    output logic [WIDTH-1:0] dp_opa,
    output logic [WIDTH-1:0] dp_opb,
    input  logic [WIDTH-1:0] dp_result,
    input  logic             dp_err,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_out,
    output logic             resp_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter preload is latency minus one so cnt==0 marks the last EXEC cycle.
    localparam logic [7:0] LM_ADD = 8'(LAT_ADD - 1);
    localparam logic [7:0] LM_SUB = 8'(LAT_SUB - 1);
    localparam logic [7:0] LM_MUL = 8'(LAT_MUL - 1);
    localparam logic [7:0] LM_DIV = 8'(LAT_DIV - 1);

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_cnt;
    logic [7:0]       w_lat_m1;
    logic             r_start;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_out;
    logic             r_err;
    logic             w_accept;
    logic             w_op_en;

    assign req_ready  = (r_state == IDLE) && !rst;
    assign w_accept   = req_valid && req_ready;
    assign w_op_en    = OP_EN[req_op];
    assign dp_start   = r_start;
    assign dp_op      = r_op;
    assign dp_opa     = r_opa;
    assign dp_opb     = r_opb;
    assign resp_valid = (r_state == RESP);
    assign resp_out   = r_out;
    assign resp_err   = r_err;
    assign busy       = (r_state != IDLE);

    always_comb begin
        w_lat_m1 = LM_ADD;
        unique case (req_op)
            2'b00: w_lat_m1 = LM_ADD;
            2'b01: w_lat_m1 = LM_SUB;
            2'b10: w_lat_m1 = LM_MUL;
            2'b11: w_lat_m1 = LM_DIV;
            default: w_lat_m1 = LM_ADD;
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = w_op_en ? EXEC : RESP;
                end
            end
            EXEC: begin
                if (r_cnt == 8'd0) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_start <= 1'b0;
            r_op    <= 2'b00;
            r_opa   <= '0;
            r_opb   <= '0;
            r_out   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_start <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op  <= req_op;
                        r_opa <= req_opa;
                        r_opb <= req_opb;
                        if (w_op_en) begin
                            r_cnt   <= w_lat_m1;
                            r_start <= 1'b1;
                        end else begin
                            r_out <= '0;
                            r_err <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (r_cnt == 8'd0) begin
                        r_out <= dp_result;
                        r_err <= dp_err;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
